// File: rtl/branch_target_predictor.sv
// Direct-mapped branch target buffer with saturating counters, a registered lookup and a sequential flush sweep.
// Optional feature: define BTB_BYPASS_EN to forward a same-cycle, same-index update into the lookup result.
module branch_target_predictor #(
    parameter int ADDR_W  = 32,
    parameter int ENTRIES = 16,
    parameter int CTR_W   = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              lk_valid,
    input  logic [ADDR_W-1:0] lk_pc,
    output logic              pred_valid,
    output logic              pred_hit,
    output logic              pred_taken,
    output logic [ADDR_W-1:0] pred_target,
    input  logic              upd_valid,
    input  logic [ADDR_W-1:0] upd_pc,
    input  logic              upd_is_branch,
    input  logic              upd_taken,
    input  logic [ADDR_W-1:0] upd_target,
    input  logic              flush_req,
    output logic              busy
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = ADDR_W - IDX_W;
    localparam logic [CTR_W-1:0] CTR_MAX  = '1;
    localparam logic [CTR_W-1:0] CTR_WEAK = CTR_W'(1) << (CTR_W - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ENTRIES - 1);

    typedef enum logic {
        ST_RUN,
        ST_FLUSH
    } state_e;

    state_e              state_q;
    logic [IDX_W-1:0]    sweep_q;
    logic                busy_q;
    logic [ENTRIES-1:0]  valid_q;
    logic [TAG_W-1:0]    tag_q [ENTRIES];
    logic [ADDR_W-1:0]   tgt_q [ENTRIES];
    logic [CTR_W-1:0]    ctr_q [ENTRIES];

    logic                pred_valid_q;
    logic                pred_hit_q;
    logic                pred_taken_q;
    logic [ADDR_W-1:0]   pred_target_q;

    logic [IDX_W-1:0]    upd_idx;
    logic [TAG_W-1:0]    upd_tag;
    logic                upd_hit;
    logic                upd_en;
    logic                wr_en;
    logic [ADDR_W-1:0]   wr_tgt;
    logic [CTR_W-1:0]    wr_ctr;

    logic [IDX_W-1:0]    lk_idx;
    logic [TAG_W-1:0]    lk_tag;
    logic                rd_valid;
    logic [TAG_W-1:0]    rd_tag;
    logic [ADDR_W-1:0]   rd_tgt;
    logic [CTR_W-1:0]    rd_ctr;
    logic                lk_hit;
    logic                lk_taken;
    logic [ADDR_W-1:0]   lk_target;

    assign upd_idx = upd_pc[IDX_W-1:0];
    assign upd_tag = upd_pc[ADDR_W-1:IDX_W];
    assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
    // A flush request in the same cycle takes priority and drops the update.
    assign upd_en  = upd_valid && (state_q == ST_RUN) && !flush_req;

    always_comb begin
        wr_en  = 1'b0;
        wr_tgt = tgt_q[upd_idx];
        wr_ctr = ctr_q[upd_idx];
        if (upd_en) begin
            if (upd_hit) begin
                wr_en = 1'b1;
                if (upd_is_branch) begin
                    if (upd_taken) begin
                        wr_tgt = upd_target;
                        wr_ctr = (ctr_q[upd_idx] == CTR_MAX) ? CTR_MAX : ctr_q[upd_idx] + CTR_W'(1);
                    end else begin
                        wr_ctr = (ctr_q[upd_idx] == '0) ? '0 : ctr_q[upd_idx] - CTR_W'(1);
                    end
                end else begin
                    wr_tgt = upd_target;
                    wr_ctr = CTR_MAX;
                end
            end else if (!upd_is_branch || upd_taken) begin
                wr_en  = 1'b1;
                wr_tgt = upd_target;
                wr_ctr = upd_is_branch ? CTR_WEAK : CTR_MAX;
            end
        end
    end

    assign lk_idx = lk_pc[IDX_W-1:0];
    assign lk_tag = lk_pc[ADDR_W-1:IDX_W];

    always_comb begin
        rd_valid = valid_q[lk_idx];
        rd_tag   = tag_q[lk_idx];
        rd_tgt   = tgt_q[lk_idx];
        rd_ctr   = ctr_q[lk_idx];
`ifdef BTB_BYPASS_EN
        if (wr_en && (upd_idx == lk_idx)) begin
            rd_valid = 1'b1;
            rd_tag   = upd_tag;
            rd_tgt   = wr_tgt;
            rd_ctr   = wr_ctr;
        end
`endif
    end

    assign lk_hit    = (state_q == ST_RUN) && rd_valid && (rd_tag == lk_tag);
    assign lk_taken  = lk_hit && rd_ctr[CTR_W-1];
    assign lk_target = lk_taken ? rd_tgt : lk_pc + ADDR_W'(1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_RUN;
            sweep_q       <= '0;
            busy_q        <= 1'b0;
            valid_q       <= '0;
            pred_valid_q  <= 1'b0;
            pred_hit_q    <= 1'b0;
            pred_taken_q  <= 1'b0;
            pred_target_q <= '0;
        end else begin
            pred_valid_q  <= lk_valid;
            pred_hit_q    <= lk_hit;
            pred_taken_q  <= lk_taken;
            pred_target_q <= lk_target;
            case (state_q)
                ST_RUN: begin
                    if (flush_req) begin
                        state_q <= ST_FLUSH;
                        sweep_q <= '0;
                        busy_q  <= 1'b1;
                    end else if (wr_en) begin
                        valid_q[upd_idx] <= 1'b1;
                    end
                end
                ST_FLUSH: begin
                    valid_q[sweep_q] <= 1'b0;
                    if (flush_req) begin
                        sweep_q <= '0;
                    end else if (sweep_q == LAST_IDX) begin
                        state_q <= ST_RUN;
                        busy_q  <= 1'b0;
                    end else begin
                        sweep_q <= sweep_q + IDX_W'(1);
                    end
                end
                default: begin
                    state_q <= ST_RUN;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Payload arrays are never reset; the valid bits gate them.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_q[upd_idx] <= upd_tag;
            tgt_q[upd_idx] <= wr_tgt;
            ctr_q[upd_idx] <= wr_ctr;
        end
    end

    assign pred_valid  = pred_valid_q;
    assign pred_hit    = pred_hit_q;
    assign pred_taken  = pred_taken_q;
    assign pred_target = pred_target_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_branch_target_predictor.sv
// Bench for branch_target_predictor: directed vector table, flush/reset sequences, and random traffic against a BTB model.
module tb_branch_target_predictor;

    localparam int N    = 16;
    localparam int CMAX = 3;

    logic        clk;
    logic        reset_n;
    logic        lk_valid;
    logic [31:0] lk_pc;
    logic        pred_valid;
    logic        pred_hit;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_is_branch;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        flush_req;
    logic        busy;

    branch_target_predictor dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .lk_valid     (lk_valid),
        .lk_pc        (lk_pc),
        .pred_valid   (pred_valid),
        .pred_hit     (pred_hit),
        .pred_taken   (pred_taken),
        .pred_target  (pred_target),
        .upd_valid    (upd_valid),
        .upd_pc       (upd_pc),
        .upd_is_branch(upd_is_branch),
        .upd_taken    (upd_taken),
        .upd_target   (upd_target),
        .flush_req    (flush_req),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Model: each slot remembers the full PC it was trained with.
    bit          m_valid [N];
    logic [31:0] m_pc    [N];
    logic [31:0] m_tgt   [N];
    int          m_ctr   [N];
    bit          m_flushing;
    int          m_sweep;

    typedef struct {
        bit          lkv;
        logic [31:0] lkpc;
        bit          uv;
        logic [31:0] upc;
        bit          ubr;
        bit          utk;
        logic [31:0] utgt;
        bit          chk;
        bit          e_hit;
        bit          e_tk;
        logic [31:0] e_tgt;
    } vec_t;

    localparam int NV = 20;
    vec_t vt [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_valid[i] = 1'b0;
        m_flushing = 1'b0;
        m_sweep    = 0;
    endtask

    task automatic step(input bit lkv, input logic [31:0] lkpc, input bit uv, input logic [31:0] upc,
                        input bit ubr, input bit utk, input logic [31:0] utgt, input bit fl);
        int          ui;
        int          li;
        bit          wr;
        int          nc;
        logic [31:0] nt;
        bit          v;
        logic [31:0] spc;
        logic [31:0] stg;
        int          sc;
        bit          e_hit;
        bit          e_tk;
        logic [31:0] e_tgt;
        lk_valid = lkv; lk_pc = lkpc; upd_valid = uv; upd_pc = upc;
        upd_is_branch = ubr; upd_taken = utk; upd_target = utgt; flush_req = fl;

        ui = int'(upc % N);
        wr = 1'b0;
        nc = m_ctr[ui];
        nt = m_tgt[ui];
        if (!m_flushing && !fl && uv) begin
            if (m_valid[ui] && m_pc[ui] == upc) begin
                wr = 1'b1;
                if (!ubr) begin
                    nc = CMAX; nt = utgt;
                end else if (utk) begin
                    nc = (nc + 1 > CMAX) ? CMAX : nc + 1; nt = utgt;
                end else begin
                    nc = (nc - 1 < 0) ? 0 : nc - 1;
                end
            end else if (!ubr || utk) begin
                wr = 1'b1; nt = utgt; nc = ubr ? (CMAX + 1) / 2 : CMAX;
            end
        end

        li  = int'(lkpc % N);
        v   = m_valid[li];
        spc = m_pc[li];
        stg = m_tgt[li];
        sc  = m_ctr[li];
`ifdef BTB_BYPASS_EN
        if (wr && ui == li) begin
            v = 1'b1; spc = upc; stg = nt; sc = nc;
        end
`endif
        e_hit = !m_flushing && v && (spc == lkpc);
        e_tk  = e_hit && (sc >= (CMAX + 1) / 2);
        e_tgt = e_tk ? stg : lkpc + 32'd1;

        if (!m_flushing) begin
            if (fl) begin
                m_flushing = 1'b1; m_sweep = 0;
            end else if (wr) begin
                m_valid[ui] = 1'b1; m_pc[ui] = upc; m_tgt[ui] = nt; m_ctr[ui] = nc;
            end
        end else begin
            m_valid[m_sweep] = 1'b0;
            if (fl) m_sweep = 0;
            else if (m_sweep == N - 1) m_flushing = 1'b0;
            else m_sweep++;
        end

        @(posedge clk);
        #1;
        chk("pred_valid", 32'(pred_valid), 32'(lkv));
        chk("busy", 32'(busy), 32'(m_flushing));
        if (lkv) begin
            chk("pred_hit", 32'(pred_hit), 32'(e_hit));
            chk("pred_taken", 32'(pred_taken), 32'(e_tk));
            chk("pred_target", pred_target, e_tgt);
        end
        lk_valid = 1'b0; upd_valid = 1'b0; flush_req = 1'b0;
    endtask

    task automatic idle();
        step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic look(input logic [31:0] pc);
        step(1'b1, pc, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic count_busy(input string name, input int exp_cycles);
        int cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (!busy) break;
            cnt++;
            step(1'b0, 32'h0, 1'b1, 32'h200 + 32'(i), 1'b0, 1'b0, 32'h700 + 32'(i), 1'b0);
        end
        chk(name, 32'(cnt), 32'(exp_cycles));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        lk_valid = 1'b0; lk_pc = '0; upd_valid = 1'b0; upd_pc = '0;
        upd_is_branch = 1'b0; upd_taken = 1'b0; upd_target = '0; flush_req = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pred_valid", 32'(pred_valid), 32'd0);
        chk("rst_pred_hit", 32'(pred_hit), 32'd0);
        chk("rst_pred_taken", 32'(pred_taken), 32'd0);
        chk("rst_pred_target", pred_target, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        reset_n = 1'b1;

        vt[0]  = '{1, 32'h40,       0, 32'h0,  0, 0, 32'h0,   1, 0, 0, 32'h41};
        vt[1]  = '{0, 32'h0,        1, 32'h40, 1, 1, 32'h80,  0, 0, 0, 32'h0};
        vt[2]  = '{1, 32'h40,       0, 32'h0,  0, 0, 32'h0,   1, 1, 1, 32'h80};
        vt[3]  = '{0, 32'h0,        1, 32'h40, 1, 0, 32'h0,   0, 0, 0, 32'h0};
        vt[4]  = '{0, 32'h0,        1, 32'h40, 1, 0, 32'h0,   0, 0, 0, 32'h0};
        vt[5]  = '{1, 32'h40,       0, 32'h0,  0, 0, 32'h0,   1, 1, 0, 32'h41};
        vt[6]  = '{0, 32'h0,        1, 32'h13, 0, 0, 32'h200, 0, 0, 0, 32'h0};
        vt[7]  = '{1, 32'h13,       0, 32'h0,  0, 0, 32'h0,   1, 1, 1, 32'h200};
        vt[8]  = '{0, 32'h0,        1, 32'h23, 1, 1, 32'h300, 0, 0, 0, 32'h0};
        vt[9]  = '{1, 32'h13,       0, 32'h0,  0, 0, 32'h0,   1, 0, 0, 32'h14};
        vt[10] = '{1, 32'h23,       0, 32'h0,  0, 0, 32'h0,   1, 1, 1, 32'h300};
`ifdef BTB_BYPASS_EN
        vt[11] = '{1, 32'h45,       1, 32'h45, 1, 1, 32'h90,  1, 1, 1, 32'h90};
`else
        vt[11] = '{1, 32'h45,       1, 32'h45, 1, 1, 32'h90,  1, 0, 0, 32'h46};
`endif
        vt[12] = '{1, 32'h45,       0, 32'h0,  0, 0, 32'h0,   1, 1, 1, 32'h90};
        vt[13] = '{1, 32'hFFFFFFFF, 0, 32'h0,  0, 0, 32'h0,   1, 0, 0, 32'h0};
        vt[14] = '{0, 32'h0,        1, 32'h7,  0, 0, 32'h123, 0, 0, 0, 32'h0};
        vt[15] = '{0, 32'h0,        1, 32'h7,  1, 1, 32'h124, 0, 0, 0, 32'h0};
        vt[16] = '{0, 32'h0,        1, 32'h7,  1, 0, 32'h0,   0, 0, 0, 32'h0};
        vt[17] = '{1, 32'h7,        0, 32'h0,  0, 0, 32'h0,   1, 1, 1, 32'h124};
        vt[18] = '{0, 32'h0,        1, 32'h7,  1, 0, 32'h0,   0, 0, 0, 32'h0};
        vt[19] = '{1, 32'h7,        0, 32'h0,  0, 0, 32'h0,   1, 1, 0, 32'h8};

        for (int i = 0; i < NV; i++) begin
            step(vt[i].lkv, vt[i].lkpc, vt[i].uv, vt[i].upc, vt[i].ubr, vt[i].utk, vt[i].utgt, 1'b0);
            if (vt[i].chk) begin
                chk($sformatf("vec%0d_hit", i), 32'(pred_hit), 32'(vt[i].e_hit));
                chk($sformatf("vec%0d_taken", i), 32'(pred_taken), 32'(vt[i].e_tk));
                chk($sformatf("vec%0d_target", i), pred_target, vt[i].e_tgt);
            end
        end

        // Fill every slot, flush with updates arriving during the sweep, then expect misses everywhere.
        for (int i = 0; i < N; i++)
            step(1'b0, 32'h0, 1'b1, 32'h100 + 32'(i), 1'b0, 1'b0, 32'h500 + 32'(i), 1'b0);
        look(32'h105);
        step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
        count_busy("flush_busy_cycles", N);
        for (int i = 0; i < N; i++) begin
            look(32'h100 + 32'(i));
            chk("post_flush_miss_a", 32'(pred_hit), 32'd0);
            look(32'h200 + 32'(i));
            chk("post_flush_miss_b", 32'(pred_hit), 32'd0);
        end

        // Flush beats a same-cycle update, and a second request restarts the sweep.
        step(1'b0, 32'h0, 1'b1, 32'h55, 1'b0, 1'b0, 32'h999, 1'b1);
        repeat (3) idle();
        step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
        count_busy("restart_busy_cycles", N);
        look(32'h55);
        chk("flush_drops_update", 32'(pred_hit), 32'd0);

        // Reset in the middle of a sweep.
        step(1'b0, 32'h0, 1'b1, 32'h40, 1'b0, 1'b0, 32'h880, 1'b0);
        step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
        repeat (4) idle();
        reset_n = 1'b0;
        #1;
        chk("midflush_rst_busy", 32'(busy), 32'd0);
        chk("midflush_rst_pred_valid", 32'(pred_valid), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        look(32'h40);
        chk("after_rst_miss", 32'(pred_hit), 32'd0);

        for (int i = 0; i < 600; i++) begin
            logic [31:0] lpc;
            lpc = ($urandom_range(0, 9) == 0) ? 32'hFFFFFFF0 + 32'($urandom_range(0, 15))
                                               : 32'($urandom_range(0, 47));
            step(1'($urandom_range(0, 4) != 0), lpc,
                 1'($urandom_range(0, 1)), 32'($urandom_range(0, 47)),
                 1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 1)), $urandom,
                 1'($urandom_range(0, 79) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
